// File: rtl/disp_pkg.sv
// Shared types and constants for the display scan controller.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GUARD,
        SHOW
    } scan_state_t;

    typedef logic [3:0] nibble_t;

    // Level that switches one anode off (anodes are active-low).
    localparam logic ANODE_OFF = 1'b1;

endpackage

// File: rtl/slot_timer.sv
// Per-digit slot counter: counts 0..REFRESH_DIV-1 and flags the end of
// the guard interval and the end of the slot.
module slot_timer #(
    parameter int REFRESH_DIV = 27000,
    parameter int GUARD_CYC   = 2,
    parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic guard_done_o,
    output logic slot_done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign guard_done_o = (cnt_q == CNT_W'(GUARD_CYC - 1));
    assign slot_done_o  = (cnt_q == CNT_W'(REFRESH_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr_i || slot_done_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Sequenced 7-segment digit scan with per-slot ghosting guard and a
// tear-free load handshake that only swaps displayed data at frame wrap.
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 27000,
    parameter int GUARD_CYC   = 2,
    parameter int IDX_W       = $clog2(N_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  load_req_i,
    input  logic [4*N_DIGITS-1:0] digits_i,
    input  logic [N_DIGITS-1:0]   blank_i,
    output logic                  load_ack_o,
    output logic [3:0]            nibble_o,
    output logic [N_DIGITS-1:0]   anode_o,
    output logic [IDX_W-1:0]      digit_idx_o,
    output logic                  frame_done_o
);

    localparam int                 CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] ALL_OFF = {N_DIGITS{ANODE_OFF}};

    scan_state_t                    state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [N_DIGITS-1:0][3:0]       shadow_dig_q, shadow_dig_d;
    logic [N_DIGITS-1:0]            shadow_blank_q, shadow_blank_d;
    logic [N_DIGITS-1:0][3:0]       stage_dig_q, stage_dig_d;
    logic [N_DIGITS-1:0]            stage_blank_q, stage_blank_d;
    logic                           pending_q, pending_d;
    logic                           ack_q, ack_d;
    logic                           frame_done_q, frame_done_d;
    logic [N_DIGITS-1:0]            anode_q, anode_d;
    nibble_t                        nibble_q, nibble_d;

    logic guard_done;
    logic slot_done;
    logic timer_clr;
    logic wrap;
    logic new_req;
    logic have_req;
    logic do_copy;

    // The slot counter only runs while actively scanning.
    assign timer_clr = (state_q == IDLE) || !en_i;

    slot_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .GUARD_CYC   (GUARD_CYC),
        .CNT_W       (CNT_W)
    ) u_slot_timer (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (timer_clr),
        .guard_done_o (guard_done),
        .slot_done_o  (slot_done)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wrap    = 1'b0;

        case (state_q)
            IDLE: begin
                if (en_i) begin
                    state_d = GUARD;
                    idx_d   = '0;
                end
            end
            GUARD: begin
                if (guard_done) begin
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (slot_done) begin
                    state_d = GUARD;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        wrap  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase

        if (state_q != IDLE && !en_i) begin
            state_d = IDLE;
            idx_d   = '0;
            wrap    = 1'b0;
        end

        // The ack cycle itself must not re-trigger; a request still high
        // after that is a fresh one.
        new_req       = load_req_i && !pending_q && !ack_q;
        stage_dig_d   = new_req ? digits_i : stage_dig_q;
        stage_blank_d = new_req ? blank_i  : stage_blank_q;
        have_req      = pending_q || new_req;
        do_copy       = have_req && ((state_q == IDLE) || wrap);

        shadow_dig_d   = do_copy ? stage_dig_d   : shadow_dig_q;
        shadow_blank_d = do_copy ? stage_blank_d : shadow_blank_q;
        pending_d      = have_req && !do_copy;
        ack_d          = do_copy;
        frame_done_d   = wrap;

        // Outputs are derived from next-state so fresh data shows on wrap.
        nibble_d = shadow_dig_d[idx_d];
        anode_d  = ALL_OFF;
        if (state_d == SHOW && !shadow_blank_d[idx_d]) begin
            anode_d[idx_d] = ~ANODE_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            shadow_dig_q   <= '0;
            shadow_blank_q <= '1;
            stage_dig_q    <= '0;
            stage_blank_q  <= '1;
            pending_q      <= 1'b0;
            ack_q          <= 1'b0;
            frame_done_q   <= 1'b0;
            anode_q        <= ALL_OFF;
            nibble_q       <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            shadow_dig_q   <= shadow_dig_d;
            shadow_blank_q <= shadow_blank_d;
            stage_dig_q    <= stage_dig_d;
            stage_blank_q  <= stage_blank_d;
            pending_q      <= pending_d;
            ack_q          <= ack_d;
            frame_done_q   <= frame_done_d;
            anode_q        <= anode_d;
            nibble_q       <= nibble_d;
        end
    end

    assign load_ack_o   = ack_q;
    assign nibble_o     = nibble_q;
    assign anode_o      = anode_q;
    assign digit_idx_o  = idx_q;
    assign frame_done_o = frame_done_q;

endmodule
